// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN flatten stage.
// Holds the BRAM geometry, the writer FSM state type and a constant log2 helper.
package cnn_pkg;

   localparam int BRAM_BITWIDTH      = 8;
   localparam int BRAM_DEPTH_FLATTEN = 256;
   localparam int CHANNELS           = 16;
   localparam int PIXELS             = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } flat_state_t;

   // Smallest r with 2**r >= value (0 for value <= 1).
   function automatic int log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   localparam int ADDR_W_FLATTEN = log2(BRAM_DEPTH_FLATTEN);

endpackage

// File: rtl/flatten_addr_gen.sv
// Flatten BRAM address generator.
// Default: linear index 0..DEPTH-1.
// With FLATTEN_CHANNEL_MAJOR_EN defined: incoming order is pixel-major, so the
// address is c*PIXELS + p, built from a channel counter, a pixel counter and a
// base accumulator that steps by PIXELS per channel (no multiplier).
module flatten_addr_gen
   import cnn_pkg::*;
#(
   parameter int DEPTH    = BRAM_DEPTH_FLATTEN,
   parameter int CHANNELS = cnn_pkg::CHANNELS,
   parameter int PIXELS   = cnn_pkg::PIXELS,
   parameter int ADDR_W   = log2(DEPTH)
) (
   input  logic              clk_x5,
   input  logic              rstn,
   input  logic              clear,
   input  logic              step,
   output logic [ADDR_W-1:0] addr
);

`ifdef FLATTEN_CHANNEL_MAJOR_EN
   localparam int CH_W = (log2(CHANNELS) > 0) ? log2(CHANNELS) : 1;
   localparam int PX_W = (log2(PIXELS) > 0) ? log2(PIXELS) : 1;
   localparam logic [CH_W-1:0]   CH_LAST = CH_W'(CHANNELS - 1);
   localparam logic [PX_W-1:0]   PX_LAST = PX_W'(PIXELS - 1);
   localparam logic [ADDR_W-1:0] PX_STEP = ADDR_W'(PIXELS);

   logic [CH_W-1:0]   chan_q, chan_d;
   logic [PX_W-1:0]   pix_q, pix_d;
   logic [ADDR_W-1:0] base_q, base_d;

   // Next channel/pixel/base: channel wraps to 0 and bumps the pixel column.
   always_comb begin
      chan_d = chan_q;
      pix_d  = pix_q;
      base_d = base_q;
      if (clear) begin
         chan_d = {CH_W{1'b0}};
         pix_d  = {PX_W{1'b0}};
         base_d = {ADDR_W{1'b0}};
      end else if (step) begin
         if (chan_q == CH_LAST) begin
            chan_d = {CH_W{1'b0}};
            base_d = {ADDR_W{1'b0}};
            if (pix_q == PX_LAST) begin
               pix_d = {PX_W{1'b0}};
            end else begin
               pix_d = pix_q + PX_W'(1);
            end
         end else begin
            chan_d = chan_q + CH_W'(1);
            base_d = base_q + PX_STEP;
            pix_d  = pix_q;
         end
      end else begin
         chan_d = chan_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk_x5 or negedge rstn) begin
      if (!rstn) begin
         chan_q <= {CH_W{1'b0}};
         pix_q  <= {PX_W{1'b0}};
         base_q <= {ADDR_W{1'b0}};
      end else begin
         chan_q <= chan_d;
         pix_q  <= pix_d;
         base_q <= base_d;
      end
   end

   assign addr = base_q + ADDR_W'(pix_q);
`else
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

   logic [ADDR_W-1:0] addr_q, addr_d;

   // Linear index; wraps only at the end of the BRAM.
   always_comb begin
      addr_d = addr_q;
      if (clear) begin
         addr_d = {ADDR_W{1'b0}};
      end else if (step) begin
         if (addr_q == ADDR_LAST) begin
            addr_d = {ADDR_W{1'b0}};
         end else begin
            addr_d = addr_q + ADDR_W'(1);
         end
      end else begin
         addr_d = addr_q;
      end
   end

   // Address register.
   always_ff @(posedge clk_x5 or negedge rstn) begin
      if (!rstn) begin
         addr_q <= {ADDR_W{1'b0}};
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr = addr_q;
`endif

endmodule

// File: rtl/pool_flatten_writer.sv
// Pool-to-flatten writer: captures pooled bytes and writes them to the flatten
// BRAM with one cycle of latency, then flags completion after DEPTH bytes.
// Address order is selected by the FLATTEN_CHANNEL_MAJOR_EN macro (see
// flatten_addr_gen).
module pool_flatten_writer
   import cnn_pkg::*;
#(
   parameter int BITWIDTH = BRAM_BITWIDTH,
   parameter int DEPTH    = BRAM_DEPTH_FLATTEN,
   parameter int CHANNELS = cnn_pkg::CHANNELS,
   parameter int PIXELS   = cnn_pkg::PIXELS,
   parameter int ADDR_W   = log2(DEPTH)
) (
   input  logic                clk_x5,
   input  logic                rstn,
   input  logic                start,
   input  logic                in_valid,
   input  logic [BITWIDTH-1:0] in_data,
   output logic                ena_flatten,
   output logic                wea_flatten,
   output logic [ADDR_W-1:0]   addra_flatten,
   output logic [BITWIDTH-1:0] dina_flatten,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   output logic [ADDR_W:0]     wr_count
);

   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

   flat_state_t         state_q, state_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   addra_q, addra_d;
   logic [BITWIDTH-1:0] dina_q, dina_d;
   logic                overflow_q, overflow_d;
   logic                done_q, done_d;
   logic [ADDR_W:0]     wr_count_q, wr_count_d;
   logic [ADDR_W-1:0]   gen_addr;
   logic                accept;

   // start has priority: a byte arriving with start is dropped silently.
   assign accept = (state_q == WRITE) && in_valid && !start;

   flatten_addr_gen #(
      .DEPTH    (DEPTH),
      .CHANNELS (CHANNELS),
      .PIXELS   (PIXELS),
      .ADDR_W   (ADDR_W)
   ) u_addr_gen (
      .clk_x5 (clk_x5),
      .rstn   (rstn),
      .clear  (start),
      .step   (accept),
      .addr   (gen_addr)
   );

   // Next state, write port and status; done lags the DONE state by a cycle.
   always_comb begin
      state_d    = state_q;
      wr_en_d    = accept;
      addra_d    = addra_q;
      dina_d     = dina_q;
      overflow_d = overflow_q;
      wr_count_d = wr_count_q;
      done_d     = (state_q == DONE) && !start;
      if (start) begin
         state_d    = WRITE;
         overflow_d = 1'b0;
         wr_count_d = {(ADDR_W + 1){1'b0}};
      end else if (accept) begin
         addra_d    = gen_addr;
         dina_d     = in_data;
         wr_count_d = wr_count_q + (ADDR_W + 1)'(1);
         if (wr_count_q == LAST_CNT) begin
            state_d = DONE;
         end else begin
            state_d = WRITE;
         end
      end else begin
         if (in_valid && (state_q != WRITE)) begin
            overflow_d = 1'b1;
         end else begin
            overflow_d = overflow_q;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk_x5 or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         wr_en_q    <= 1'b0;
         addra_q    <= {ADDR_W{1'b0}};
         dina_q     <= {BITWIDTH{1'b0}};
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         wr_count_q <= {(ADDR_W + 1){1'b0}};
      end else begin
         state_q    <= state_d;
         wr_en_q    <= wr_en_d;
         addra_q    <= addra_d;
         dina_q     <= dina_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign ena_flatten   = wr_en_q;
   assign wea_flatten   = wr_en_q;
   assign addra_flatten = addra_q;
   assign dina_flatten  = dina_q;
   assign busy          = (state_q == WRITE);
   assign done          = done_q;
   assign overflow      = overflow_q;
   assign wr_count      = wr_count_q;

endmodule
